// File: rtl/cpu_pkg.sv
// Shared constants for the sequencer CPU datapath: comparison codes and
// well-known register indices.
package cpu_pkg;

  localparam logic [7:0] CMP_LT = 8'd1;
  localparam logic [7:0] CMP_EQ = 8'd2;
  localparam logic [7:0] CMP_GT = 8'd3;

  localparam logic [3:0] REG_ZERO = 4'd0;
  localparam logic [3:0] REG_ARG  = 4'd1;
  localparam logic [3:0] REG_SYS  = 4'd8;
  localparam logic [3:0] REG_CMP  = 4'd9;
  localparam logic [3:0] REG_PC   = 4'd12;

endpackage

// File: rtl/dp_magnitude_cmp.sv
// Unsigned magnitude comparator producing the CPU comparison code
// (1 = less, 2 = equal, 3 = greater); code 0 is never produced.
module dp_magnitude_cmp
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_code
);

  // Equal is the default; the two strict orderings override it.
  always_comb begin
    o_code = WIDTH'(CMP_EQ);
    if (i_a < i_b) begin
      o_code = WIDTH'(CMP_LT);
    end else if (i_a > i_b) begin
      o_code = WIDTH'(CMP_GT);
    end
  end

endmodule

// File: rtl/cpu_datapath.sv
// Storage-and-compare datapath: 16 x 8 register file (2R/1W), 256 x 8 data
// RAM and a comparator whose result can be latched into the $cmp register.
// The sequencer owns all ids, addresses and enables; $pc is a plain register.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int                  DATA_W     = 8,
  parameter int                  REG_ID_W   = 4,
  parameter int                  RAM_ADDR_W = 8,
  parameter logic [REG_ID_W-1:0] CMP_REG    = REG_CMP
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ID_W-1:0]   read1_id,
  output logic [DATA_W-1:0]     read1_value,
  input  logic [REG_ID_W-1:0]   read2_id,
  output logic [DATA_W-1:0]     read2_value,
  input  logic [REG_ID_W-1:0]   write_id,
  input  logic [DATA_W-1:0]     write_value,
  input  logic [RAM_ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0]     ram_data,
  input  logic                  ram_write,
  input  logic [DATA_W-1:0]     ram_write_data,
  input  logic [DATA_W-1:0]     cmp_a,
  input  logic [DATA_W-1:0]     cmp_b,
  output logic [DATA_W-1:0]     cmp_out,
  input  logic                  cmp_store
);

  localparam int NUM_REGS  = 2 ** REG_ID_W;
  localparam int NUM_WORDS = 2 ** RAM_ADDR_W;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  // RAM powers up cleared and is deliberately left out of reset.
  logic [DATA_W-1:0] r_mem  [NUM_WORDS] = '{default: '0};

  logic [DATA_W-1:0] w_cmp_code;
  logic              w_reg_write;

  dp_magnitude_cmp #(
    .WIDTH (DATA_W)
  ) u_cmp (
    .i_a    (cmp_a),
    .i_b    (cmp_b),
    .o_code (w_cmp_code)
  );

  assign cmp_out = w_cmp_code;

  // Register 0 is hard-wired to zero on both read ports; no bypass on reads.
  assign read1_value = (read1_id == REG_ID_W'(REG_ZERO)) ? '0 : r_regs[read1_id];
  assign read2_value = (read2_id == REG_ID_W'(REG_ZERO)) ? '0 : r_regs[read2_id];
  assign ram_data    = r_mem[ram_address];

  // A normal write to the $cmp register loses to a simultaneous cmp_store.
  assign w_reg_write = (write_id != REG_ID_W'(REG_ZERO)) &&
                       !(cmp_store && (write_id == CMP_REG));

  // Register file update: reset clears everything and suppresses both writers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_reg_write) begin
        r_regs[write_id] <= write_value;
      end
      if (cmp_store) begin
        r_regs[CMP_REG] <= w_cmp_code;
      end
    end
  end

  // RAM write port, independent of reset.
  always_ff @(posedge clock) begin
    if (ram_write) begin
      r_mem[ram_address] <= ram_write_data;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus a randomized
// run, all checked against a behavioural array model of the datapath.
module tb_cpu_datapath;

  logic       clock;
  logic       reset;
  logic [3:0] read1_id, read2_id, write_id;
  logic [7:0] read1_value, read2_value, write_value;
  logic [7:0] ram_address, ram_data, ram_write_data;
  logic       ram_write;
  logic [7:0] cmp_a, cmp_b, cmp_out;
  logic       cmp_store;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_regs [16];
  logic [7:0] m_mem  [256];

  cpu_datapath dut (
    .clock          (clock),
    .reset          (reset),
    .read1_id       (read1_id),
    .read1_value    (read1_value),
    .read2_id       (read2_id),
    .read2_value    (read2_value),
    .write_id       (write_id),
    .write_value    (write_value),
    .ram_address    (ram_address),
    .ram_data       (ram_data),
    .ram_write      (ram_write),
    .ram_write_data (ram_write_data),
    .cmp_a          (cmp_a),
    .cmp_b          (cmp_b),
    .cmp_out        (cmp_out),
    .cmp_store      (cmp_store)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] cmp_ref(input int a, input int b);
    if (a < b) return 8'd1;
    if (a == b) return 8'd2;
    return 8'd3;
  endfunction

  function automatic logic [7:0] reg_ref(input logic [3:0] id);
    return (id == 4'd0) ? 8'd0 : m_regs[id];
  endfunction

  // Advance the model by one rising edge using the current inputs, then the DUT.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;
    end else begin
      if (write_id != 4'd0) m_regs[write_id] = write_value;
      if (cmp_store) m_regs[9] = cmp_ref(int'(cmp_a), int'(cmp_b));
    end
    if (ram_write) m_mem[ram_address] = ram_write_data;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; write_id = 4'd0; write_value = 8'd0;
    ram_write = 1'b0; ram_write_data = 8'd0; cmp_store = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read1_id = 4'd5; read2_id = 4'd12; ram_address = 8'h33;
    #1;
    total++; if (read1_value !== 8'h00) begin bad++; $display("FAIL reset_r5 got=%h exp=00", read1_value); end
    total++; if (read2_value !== 8'h00) begin bad++; $display("FAIL reset_r12 got=%h exp=00", read2_value); end
    total++; if (ram_data !== 8'h00) begin bad++; $display("FAIL ram_init got=%h exp=00", ram_data); end
  endtask

  task automatic test_reg_zero();
    write_id = 4'd0; write_value = 8'hFF;
    tick();
    idle_inputs();
    read1_id = 4'd0; #1;
    total++; if (read1_value !== 8'h00) begin bad++; $display("FAIL reg0_write got=%h exp=00", read1_value); end
  endtask

  task automatic test_reg_write_rdw();
    write_id = 4'd3; write_value = 8'h41;
    tick();
    idle_inputs();
    read1_id = 4'd3; #1;
    total++; if (read1_value !== 8'h41) begin bad++; $display("FAIL r3_write got=%h exp=41", read1_value); end
    write_id = 4'd3; write_value = 8'h55; read2_id = 4'd3; #1;
    total++; if (read2_value !== 8'h41) begin bad++; $display("FAIL rdw_before got=%h exp=41", read2_value); end
    tick();
    idle_inputs(); #1;
    total++; if (read2_value !== 8'h55) begin bad++; $display("FAIL rdw_after got=%h exp=55", read2_value); end
  endtask

  task automatic test_compare();
    cmp_a = 8'd5; cmp_b = 8'd9; #1;
    total++; if (cmp_out !== 8'd1) begin bad++; $display("FAIL cmp_lt got=%0d exp=1", cmp_out); end
    cmp_a = 8'd9; cmp_b = 8'd9; #1;
    total++; if (cmp_out !== 8'd2) begin bad++; $display("FAIL cmp_eq got=%0d exp=2", cmp_out); end
    cmp_a = 8'd200; cmp_b = 8'd7; #1;
    total++; if (cmp_out !== 8'd3) begin bad++; $display("FAIL cmp_gt_unsigned got=%0d exp=3", cmp_out); end
    cmp_store = 1'b1;
    tick();
    idle_inputs();
    read1_id = 4'd9; #1;
    total++; if (read1_value !== 8'd3) begin bad++; $display("FAIL cmp_store got=%h exp=03", read1_value); end
  endtask

  task automatic test_cmp_store_priority();
    cmp_a = 8'd42; cmp_b = 8'd42; cmp_store = 1'b1;
    write_id = 4'd9; write_value = 8'h77;
    tick();
    idle_inputs();
    read1_id = 4'd9; #1;
    total++; if (read1_value !== 8'd2) begin bad++; $display("FAIL cmp_wins got=%h exp=02", read1_value); end
    // Seed reg 9 with something else so the parallel store is visible.
    write_id = 4'd9; write_value = 8'hEE;
    tick();
    cmp_store = 1'b1; write_id = 4'd4; write_value = 8'h77;
    tick();
    idle_inputs();
    read1_id = 4'd4; read2_id = 4'd9; #1;
    total++; if (read1_value !== 8'h77) begin bad++; $display("FAIL parallel_r4 got=%h exp=77", read1_value); end
    total++; if (read2_value !== 8'd2) begin bad++; $display("FAIL parallel_r9 got=%h exp=02", read2_value); end
  endtask

  task automatic test_ram();
    ram_address = 8'h10; ram_write_data = 8'hAB; ram_write = 1'b1;
    tick();
    idle_inputs(); #1;
    total++; if (ram_data !== 8'hAB) begin bad++; $display("FAIL ram_10 got=%h exp=ab", ram_data); end
    ram_address = 8'hFF; ram_write_data = 8'h01; ram_write = 1'b1; #1;
    total++; if (ram_data !== 8'h00) begin bad++; $display("FAIL ram_rdw_before got=%h exp=00", ram_data); end
    tick();
    idle_inputs(); #1;
    total++; if (ram_data !== 8'h01) begin bad++; $display("FAIL ram_ff got=%h exp=01", ram_data); end
    ram_address = 8'h10; #1;
    total++; if (ram_data !== 8'hAB) begin bad++; $display("FAIL ram_10_kept got=%h exp=ab", ram_data); end
  endtask

  task automatic test_reset_midseq();
    write_id = 4'd7; write_value = 8'h99;
    ram_address = 8'h20; ram_write_data = 8'h5A; ram_write = 1'b1;
    tick();
    idle_inputs();
    reset = 1'b1; write_id = 4'd7; write_value = 8'h33; cmp_store = 1'b1;
    ram_address = 8'h21; ram_write_data = 8'hC3; ram_write = 1'b1;
    tick();
    idle_inputs();
    read1_id = 4'd7; read2_id = 4'd9; ram_address = 8'h20; #1;
    total++; if (read1_value !== 8'h00) begin bad++; $display("FAIL rst_r7 got=%h exp=00", read1_value); end
    total++; if (read2_value !== 8'h00) begin bad++; $display("FAIL rst_r9 got=%h exp=00", read2_value); end
    total++; if (ram_data !== 8'h5A) begin bad++; $display("FAIL rst_ram20 got=%h exp=5a", ram_data); end
    ram_address = 8'h21; #1;
    total++; if (ram_data !== 8'hC3) begin bad++; $display("FAIL rst_ramwrite got=%h exp=c3", ram_data); end
  endtask

  task automatic test_random();
    logic [7:0] e1, e2, ed, ec;
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 19) == 0);
      read1_id       = 4'($urandom);
      read2_id       = 4'($urandom);
      write_id       = 4'($urandom);
      write_value    = 8'($urandom);
      ram_address    = 8'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 8'hF0 : 8'h00);
      ram_write      = $urandom_range(0, 1) == 1;
      ram_write_data = 8'($urandom);
      cmp_a          = 8'($urandom);
      cmp_b          = ($urandom_range(0, 3) == 0) ? cmp_a : 8'($urandom);
      cmp_store      = $urandom_range(0, 2) == 0;
      #1;
      e1 = reg_ref(read1_id);
      e2 = reg_ref(read2_id);
      ed = m_mem[ram_address];
      ec = cmp_ref(int'(cmp_a), int'(cmp_b));
      total++; if (read1_value !== e1) begin bad++; $display("FAIL rnd_read1 n=%0d id=%0d got=%h exp=%h", n, read1_id, read1_value, e1); end
      total++; if (read2_value !== e2) begin bad++; $display("FAIL rnd_read2 n=%0d id=%0d got=%h exp=%h", n, read2_id, read2_value, e2); end
      total++; if (ram_data !== ed) begin bad++; $display("FAIL rnd_ram n=%0d addr=%h got=%h exp=%h", n, ram_address, ram_data, ed); end
      total++; if (cmp_out !== ec) begin bad++; $display("FAIL rnd_cmp n=%0d a=%0d b=%0d got=%0d exp=%0d", n, cmp_a, cmp_b, cmp_out, ec); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;
    idle_inputs();
    read1_id = 4'd0; read2_id = 4'd0; ram_address = 8'd0;
    cmp_a = 8'd0; cmp_b = 8'd0;
    @(negedge clock);

    test_reset();
    test_reg_zero();
    test_reg_write_rdw();
    test_compare();
    test_cmp_store_priority();
    test_ram();
    test_reset_midseq();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
